// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per clock.
// Latency: XLEN+1 cycles from accept to done (XLEN CALC + 1 FIX); divide-by-zero/overflow take 1 cycle.
// Backpressure: start is taken only while idle; busy stalls the pipeline, no queuing, kill abandons the op.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start, kill   one-cycle request (sampled in IDLE) / pipeline flush
//   op            funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b          dividend (rs1), divisor (rs2), sampled with an accepted start
//   busy, done    op in flight / one-cycle result-valid pulse
//   result        quotient or remainder, held until the next completed op
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand decode, evaluated on the live inputs; only used in the accept cycle.
    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_by_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_val;

    // Iteration and fix-up state.
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            rem_op_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            spec_q;
    logic [XLEN-1:0] spec_val_q;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;
    logic            last_iter;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_val;

    assign accept    = start && (state_q == IDLE) && !kill;
    assign is_signed = ~op[0];
    assign is_rem    = op[1];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_abs     = a_neg ? (~a + 1'b1) : a;
    assign b_abs     = b_neg ? (~b + 1'b1) : b;

    assign div_by_zero = (b == '0);
    assign overflow    = is_signed && (a == MIN_NEG) && (b == '1);
    assign special     = div_by_zero || overflow;

    // RISC-V defined results for the two cases the iteration would get wrong.
    always_comb begin
        special_val = '0;
        if (div_by_zero) begin
            special_val = is_rem ? a : '1;
        end else if (overflow) begin
            special_val = is_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder,
    // then try to subtract the divisor. The extra top bit of diff is the borrow.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign fits      = ~diff[XLEN];
    assign last_iter = (cnt_q == CW'(XLEN-1));

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    assign fix_val = spec_q ? spec_val_q : (rem_op_q ? rem_fix : quo_fix);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? FIX : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A flush abandons whatever is in flight; in IDLE accept already excludes kill.
        if (kill) begin
            state_d = IDLE;
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            rem_op_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result     <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rem_q      <= '0;
                quo_q      <= a_abs;
                dvs_q      <= b_abs;
                cnt_q      <= '0;
                rem_op_q   <= is_rem;
                neg_quo_q  <= ~is_rem & (a_neg ^ b_neg);
                neg_rem_q  <= is_rem & a_neg;
                spec_q     <= special;
                spec_val_q <= special_val;
            end else if (state_q == CALC && !kill) begin
                rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], fits};
                cnt_q <= cnt_q + CW'(1);
            end else if (state_q == FIX && !kill) begin
                result <= fix_val;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks begin and end 1ns after a rising edge.
    // Drive a start pulse; returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; lat stays 0 if the bound expires.
    task automatic wait_done(input int offset, output int lat);
        lat = 0;
        for (int n = offset + 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; kill = 1'b0; op = OP_DIVU; a = 32'd9; b = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            $display("FAIL reset_outputs busy=%b done=%b result=%h required 0/0/0", busy, done, result);
        end else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy=%b required 0", busy);
        else pass_cnt++;
        // kill together with start in IDLE drops the start
        kill = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd3);
        kill = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL kill_drops_start busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_unsigned;
        int lat;
        issue(OP_DIVU, 32'd100, 32'd7);
        total++;
        if (busy !== 1'b1) $display("FAIL divu_busy busy=%b required 1", busy);
        else pass_cnt++;
        wait_done(0, lat);
        total++;
        if (lat != 33) $display("FAIL divu_latency got=%0d required 33", lat);
        else pass_cnt++;
        total++;
        if (result !== 32'd14 || busy !== 1'b0)
            $display("FAIL divu_result result=%h busy=%b required 0000000e/0", result, busy);
        else pass_cnt++;
        issue(OP_REMU, 32'd100, 32'd7);
        wait_done(0, lat);
        total++;
        if (result !== 32'd2 || lat != 33)
            $display("FAIL remu_result result=%h lat=%0d required 00000002/33", result, lat);
        else pass_cnt++;
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        wait_done(0, lat);
        total++;
        if (result !== 32'hFFFF_FFFF) $display("FAIL divu_max result=%h required ffffffff", result);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        int lat;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat);
        total++;
        if (result !== 32'hFFFF_FFFD || lat != 33)
            $display("FAIL div_neg result=%h lat=%0d required fffffffd/33", result, lat);
        else pass_cnt++;
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat);
        total++;
        if (result !== 32'hFFFF_FFFF) $display("FAIL rem_neg result=%h required ffffffff", result);
        else pass_cnt++;
        issue(OP_REM, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, lat);
        total++;
        if (result !== 32'd1) $display("FAIL rem_negdiv result=%h required 00000001", result);
        else pass_cnt++;
    endtask

    task automatic test_special;
        int lat;
        issue(OP_DIV, 32'h1234, 32'd0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL divzero_busy busy=%b done=%b required 1/0", busy, done);
        else pass_cnt++;
        wait_done(0, lat);
        total++;
        if (result !== 32'hFFFF_FFFF || lat != 1 || busy !== 1'b0)
            $display("FAIL divzero_div result=%h lat=%0d busy=%b required ffffffff/1/0", result, lat, busy);
        else pass_cnt++;
        issue(OP_REMU, 32'h1234, 32'd0);
        wait_done(0, lat);
        total++;
        if (result !== 32'h1234 || lat != 1)
            $display("FAIL divzero_remu result=%h lat=%0d required 00001234/1", result, lat);
        else pass_cnt++;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat);
        total++;
        if (result !== 32'h8000_0000 || lat != 1)
            $display("FAIL ovf_div result=%h lat=%0d required 80000000/1", result, lat);
        else pass_cnt++;
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat);
        total++;
        if (result !== 32'd0 || lat != 1)
            $display("FAIL ovf_rem result=%h lat=%0d required 00000000/1", result, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        issue(OP_REMU, 32'd50, 32'd3);  // lands on edge k+5 while busy
        a = 32'd1; b = 32'd1; op = OP_DIV;  // operand churn while busy
        wait_done(5, lat);
        total++;
        if (result !== 32'd14 || lat != 33)
            $display("FAIL ignore_start result=%h lat=%0d required 0000000e/33", result, lat);
        else pass_cnt++;
        issue(OP_REMU, 32'd100, 32'd7);  // start asserted in the done cycle
        total++;
        if (busy !== 1'b1) $display("FAIL start_in_done busy=%b required 1", busy);
        else pass_cnt++;
        wait_done(0, lat);
        total++;
        if (result !== 32'd2 || lat != 33)
            $display("FAIL b2b_result result=%h lat=%0d required 00000002/33", result, lat);
        else pass_cnt++;
    endtask

    task automatic test_kill_rst;
        int lat;
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd2)
            $display("FAIL kill_state busy=%b done=%b result=%h required 0/0/00000002", busy, done, result);
        else pass_cnt++;
        wait_done(0, lat);
        total++;
        if (lat != 0 || result !== 32'd2)
            $display("FAIL kill_no_done lat=%0d result=%h required 0/00000002", lat, result);
        else pass_cnt++;
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0)
            $display("FAIL rst_midop busy=%b done=%b result=%h required 0/0/00000000", busy, done, result);
        else pass_cnt++;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat);
        total++;
        if (result !== 32'hFFFF_FFFD || lat != 33)
            $display("FAIL fresh_after_rst result=%h lat=%0d required fffffffd/33", result, lat);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_kill_rst();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
